// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: host address geometry and request-issue FSM encodings.
package sdram_pkg;

  localparam int BANK_WIDTH  = 2;
  localparam int ROW_WIDTH   = 13;
  localparam int COL_WIDTH   = 10;
  localparam int HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO with occupancy output; pointers wrap modulo DEPTH (power of two).
module sdram_req_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Host request front end for the SDRAM controller: buffers byte requests, issues them
// one at a time on the wr/rd enable + ack interface, and returns read data with timeout.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = sdram_pkg::HADDR_WIDTH,
  parameter int DEPTH       = 4,
  parameter int RD_TIMEOUT  = 63,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Handshakes: a transfer happens on the clock edge where valid && ready are both 1;
  // valid never depends on ready, and ready never depends combinationally on ctl_ack.
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [7:0]             ctl_wr_data,
  output logic                   ctl_wr_enable,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic                   ctl_rd_enable,
  input  logic                   ctl_ack,
  input  logic                   ctl_rd_ready,
  input  logic [7:0]             ctl_rd_data,
  output logic [LW-1:0]          fifo_level,
  output state_t                 dbg_state
);

  localparam int W  = 1 + HADDR_WIDTH + 8;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [W-1:0]           w_head;
  logic                   w_head_we;
  logic [HADDR_WIDTH-1:0] w_head_addr;
  logic [7:0]             w_head_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  state_t                 r_state, w_nxt_state;
  logic [HADDR_WIDTH-1:0] r_wr_addr, w_nxt_wr_addr;
  logic [7:0]             r_wr_data, w_nxt_wr_data;
  logic                   r_wr_en, w_nxt_wr_en;
  logic [HADDR_WIDTH-1:0] r_rd_addr, w_nxt_rd_addr;
  logic                   r_rd_en, w_nxt_rd_en;
  logic                   r_rsp_valid, w_nxt_rsp_valid;
  logic [7:0]             r_rsp_data, w_nxt_rsp_data;
  logic                   r_rsp_err, w_nxt_rsp_err;
  logic [TW-1:0]          r_cnt, w_nxt_cnt;

  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready;

  sdram_req_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({req_we, req_addr, req_wdata}),
    .pop       (w_pop),
    .head      (w_head),
    .level     (fifo_level),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_head_we   = w_head[W-1];
  assign w_head_addr = w_head[W-2:8];
  assign w_head_data = w_head[7:0];

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_wr_addr   = r_wr_addr;
    w_nxt_wr_data   = r_wr_data;
    w_nxt_wr_en     = r_wr_en;
    w_nxt_rd_addr   = r_rd_addr;
    w_nxt_rd_en     = r_rd_en;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_data  = r_rsp_data;
    w_nxt_rsp_err   = r_rsp_err;
    w_nxt_cnt       = r_cnt;
    w_pop           = 1'b0;

    if (r_rsp_valid && rsp_ready) w_nxt_rsp_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A read waits until the response register is free so it can never be overwritten.
        if (!w_empty && (w_head_we || !r_rsp_valid)) begin
          w_nxt_state = S_ISSUE;
          if (w_head_we) begin
            w_nxt_wr_addr = w_head_addr;
            w_nxt_wr_data = w_head_data;
            w_nxt_wr_en   = 1'b1;
          end else begin
            w_nxt_rd_addr = w_head_addr;
            w_nxt_rd_en   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (ctl_ack) begin
          w_pop       = 1'b1;
          w_nxt_wr_en = 1'b0;
          w_nxt_rd_en = 1'b0;
          if (r_rd_en) begin
            w_nxt_state = S_RDWAIT;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      S_RDWAIT: begin
        if (ctl_rd_ready) begin
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_data  = ctl_rd_data;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_state     = S_IDLE;
        end else if (r_cnt == TW'(RD_TIMEOUT)) begin
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_data  = 8'h00;
          w_nxt_rsp_err   = 1'b1;
          w_nxt_state     = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_wr_addr   <= w_nxt_wr_addr;
      r_wr_data   <= w_nxt_wr_data;
      r_wr_en     <= w_nxt_wr_en;
      r_rd_addr   <= w_nxt_rd_addr;
      r_rd_en     <= w_nxt_rd_en;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_data  <= w_nxt_rsp_data;
      r_rsp_err   <= w_nxt_rsp_err;
      r_cnt       <= w_nxt_cnt;
    end
  end

  assign ctl_wr_addr   = r_wr_addr;
  assign ctl_wr_data   = r_wr_data;
  assign ctl_wr_enable = r_wr_en;
  assign ctl_rd_addr   = r_rd_addr;
  assign ctl_rd_enable = r_rd_en;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed self-checking bench for sdram_req_queue with a hand-driven controller.
module tb_sdram_req_queue;
  import sdram_pkg::*;

  localparam int AW  = 25;
  localparam int TO  = 63;
  localparam int W   = 1 + AW + 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [7:0]    rsp_data;
  logic [AW-1:0] ctl_wr_addr, ctl_rd_addr;
  logic [7:0]    ctl_wr_data, ctl_rd_data;
  logic          ctl_wr_enable, ctl_rd_enable, ctl_ack, ctl_rd_ready;
  logic [2:0]    fifo_level;
  state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  sdram_req_queue #(.HADDR_WIDTH(AW), .DEPTH(4), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
    .ctl_ack(ctl_ack), .ctl_rd_ready(ctl_rd_ready), .ctl_rd_data(ctl_rd_data),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock; a request accepted on this edge is withdrawn afterwards.
  task automatic step();
    logic acc;
    acc = req_valid && req_ready;
    @(posedge clk);
    #1;
    if (acc) req_valid = 1'b0;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] addr, input logic [7:0] data);
    int n;
    req_we = we; req_addr = addr; req_wdata = data; req_valid = 1'b1;
    n = 0;
    while (req_valid && n < 50) begin step(); n++; end
    if (req_valid) begin
      check("push_timeout", 1'b1, 1'b0);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_en(output logic ok);
    int n;
    n = 0;
    while (!(ctl_wr_enable || ctl_rd_enable) && n < 50) begin step(); n++; end
    ok = ctl_wr_enable || ctl_rd_enable;
    if (!ok) check("enable_timeout", 1'b0, 1'b1);
  endtask

  // Controller side: wait for an issue, compare it with the queue head, ack after delay cycles.
  task automatic serve(input int delay);
    logic ok;
    logic [W-1:0] got, exp;
    wait_en(ok);
    if (!ok) return;
    check("one_enable", ctl_wr_enable && ctl_rd_enable, 1'b0);
    got = ctl_wr_enable ? {1'b1, ctl_wr_addr, ctl_wr_data} : {1'b0, ctl_rd_addr, 8'h00};
    if (exp_q.size() == 0) begin
      check("unexpected_issue", got, '0);
    end else begin
      exp = exp_q.pop_front();
      check("issue_order", got, exp);
    end
    repeat (delay) step();
    ctl_ack = 1'b1;
    step();
    ctl_ack = 1'b0;
    check("enable_drop", {ctl_wr_enable, ctl_rd_enable}, 2'b00);
  endtask

  task automatic rd_pulse(input logic [7:0] d);
    ctl_rd_ready = 1'b1; ctl_rd_data = d;
    step();
    ctl_rd_ready = 1'b0; ctl_rd_data = 8'h00;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic ok;
    logic seen;
    int n;
    rst_n = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0; ctl_ack = 0; ctl_rd_ready = 0; ctl_rd_data = '0;

    // asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", {rsp_valid, rsp_data, rsp_err, ctl_wr_addr, ctl_wr_data, ctl_wr_enable,
                          ctl_rd_addr, ctl_rd_enable}, '0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_level", fifo_level, 3'd0);
    check("rst_state", dbg_state, S_IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // write held for ack three cycles after enable rises
    push(1'b1, 25'h0001234, 8'hA5);
    wait_en(ok);
    check("wr_c1", {ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data}, {2'b10, 25'h0001234, 8'hA5});
    repeat (3) begin
      step();
      check("wr_hold", {ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data}, {2'b10, 25'h0001234, 8'hA5});
    end
    ctl_ack = 1'b1;
    step();
    ctl_ack = 1'b0;
    check("wr_drop", ctl_wr_enable, 1'b0);
    check("wr_level", fifo_level, 3'd0);
    step();
    check("wr_no_rsp", rsp_valid, 1'b0);

    // read with ack after one cycle, data six cycles later
    push(1'b0, 25'h1FFFFFF, 8'h00);
    wait_en(ok);
    check("rd_issue", {ctl_rd_enable, ctl_wr_enable, ctl_rd_addr}, {2'b10, 25'h1FFFFFF});
    step();
    ctl_ack = 1'b1;
    step();
    ctl_ack = 1'b0;
    check("rd_drop", ctl_rd_enable, 1'b0);
    repeat (5) step();
    check("rd_wait_norsp", rsp_valid, 1'b0);
    rd_pulse(8'h3C);
    check("rd_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h3C});
    repeat (3) step();
    check("rd_rsp_held", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h3C});
    consume();
    check("rd_rsp_clear", rsp_valid, 1'b0);

    // fill the FIFO with acks withheld, then drain in order
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b1, 25'(32'h100 + k), 8'(8'h10 + k)});
      push(1'b1, 25'(32'h100 + k), 8'(8'h10 + k));
    end
    check("full_level", fifo_level, 3'd4);
    check("full_ready", req_ready, 1'b0);
    exp_q.push_back({1'b1, 25'h0000104, 8'h14});
    req_we = 1'b1; req_addr = 25'h0000104; req_wdata = 8'h14; req_valid = 1'b1;
    repeat (2) step();
    check("full_no_push", fifo_level, 3'd4);
    repeat (5) serve(0);
    step();
    check("drain_level", fifo_level, 3'd0);
    check("drain_q_empty", exp_q.size(), 0);

    // second read held back while the first response is unconsumed
    exp_q.push_back({1'b0, 25'h0AAAAAA, 8'h00});
    exp_q.push_back({1'b0, 25'h1555555, 8'h00});
    push(1'b0, 25'h0AAAAAA, 8'h00);
    push(1'b0, 25'h1555555, 8'h00);
    serve(1);
    repeat (2) step();
    rd_pulse(8'h11);
    check("rd1_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h11});
    seen = 1'b0;
    repeat (10) begin step(); seen |= ctl_rd_enable; end
    check("rd2_blocked", seen, 1'b0);
    check("rd2_queued", fifo_level, 3'd1);
    consume();
    serve(0);
    step();
    rd_pulse(8'h22);
    check("rd2_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h22});
    consume();

    // read timeout, then a late rd_ready is ignored
    exp_q.push_back({1'b0, 25'h0000FF0, 8'h00});
    push(1'b0, 25'h0000FF0, 8'h00);
    serve(0);
    n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    check("to_window", (n >= TO) && (n <= TO + 2), 1'b1);
    check("to_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00});
    rd_pulse(8'h77);
    check("to_late_ignored", {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00});
    consume();
    rd_pulse(8'h55);
    step();
    check("late_no_rsp", rsp_valid, 1'b0);

    // spurious ack while idle
    ctl_ack = 1'b1;
    step();
    ctl_ack = 1'b0;
    check("spurious_ack", {fifo_level, ctl_wr_enable, ctl_rd_enable, dbg_state}, {3'd0, 2'b00, S_IDLE});

    // reset in the middle of a transaction
    push(1'b1, 25'h0000ABC, 8'h5A);
    push(1'b0, 25'h0000DEF, 8'h00);
    wait_en(ok);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst", {ctl_wr_enable, ctl_rd_enable, fifo_level, req_ready, rsp_valid}, {2'b00, 3'd0, 2'b10});
    step();
    #2 rst_n = 1'b1;
    repeat (4) step();
    check("post_rst_quiet", {ctl_wr_enable, ctl_rd_enable, fifo_level, rsp_valid}, {2'b00, 3'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
Host-side request front end that sits directly upstream of the SDRAM controller. It accepts byte read/write requests from host logic over a valid/ready interface and buffers them in a small FIFO. It issues the requests one at a time on the controller's wr_enable/rd_enable/ack interface. Read data is returned to the host through a one-entry response register with valid/ready and a timeout error flag.

Parameters:
HADDR_WIDTH, 25, host byte address width (bank+row+col = 2+13+10)
DEPTH, 4, request FIFO entries; power of two, minimum 2
RD_TIMEOUT, 63, cycles to wait for ctl_rd_ready after ack before flagging an error

Ports:
clk  in  1  system clock; same clock as the SDRAM controller's clk
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  FIFO not full
req_we  in  1  1 = write, 0 = read
req_addr  in  HADDR_WIDTH  byte address
req_wdata  in  8  write data; ignored for reads
rsp_valid  out  1  read response valid
rsp_ready  in  1  host accepts response
rsp_data  out  8  read data
rsp_err  out  1  response produced by timeout; rsp_data = 8'h00
ctl_wr_addr  out  HADDR_WIDTH  to controller wr_addr
ctl_wr_data  out  8  to controller wr_data
ctl_wr_enable  out  1  to controller wr_enable
ctl_rd_addr  out  HADDR_WIDTH  to controller rd_addr
ctl_rd_enable  out  1  to controller rd_enable
ctl_ack  in  1  controller accepted the request (1-cycle pulse)
ctl_rd_ready  in  1  controller read data valid (1-cycle pulse)
ctl_rd_data  in  8  controller read data
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM in S_IDLE, every output 0 except req_ready=1.
- FIFO push: occurs when req_valid && req_ready. Pop occurs on the ack of the head entry. Simultaneous push and pop at full is not allowed: req_ready depends only on level<DEPTH, with no combinational path from ctl_ack. Pointers wrap modulo DEPTH.
- Issue FSM, all outputs registered:
  - S_IDLE: if FIFO not empty, and for a head read also rsp_valid==0 → S_ISSUE. Load ctl_*_addr/data from the head and assert exactly one of ctl_wr_enable/ctl_rd_enable.
  - S_ISSUE: hold the enable and the address/data stable until ctl_ack==1, indefinitely (the controller ignores enables while refreshing or busy). On ack: drop the enable next cycle and pop the FIFO. A write → S_IDLE; a read → S_RDWAIT with the timeout counter cleared.
  - S_RDWAIT: on ctl_rd_ready, capture ctl_rd_data into rsp_data, set rsp_valid, rsp_err=0, and go to S_IDLE. If the counter reaches RD_TIMEOUT first, set rsp_valid, rsp_err=1, rsp_data=0, and go to S_IDLE. A ctl_rd_ready that arrives in any other state is ignored.
- The enable is still high during the ack cycle (registered). This is legal because the controller has left its idle state by then. The enable must be low by the following cycle.
- Response register: rsp_valid clears on rsp_valid && rsp_ready. A new read is not issued while rsp_valid==1, so at most one read is outstanding and the response can never be overwritten. Writes issue regardless of rsp_valid.
- Ordering: strict FIFO order; a write after a read to the same address is not issued until the read response is captured.
- ctl_ack while in S_IDLE or S_RDWAIT (spurious): ignored, no pop.
- Reset mid-transaction: FIFO contents and any outstanding read are discarded with no response. The controller shares rst_n and re-initialises.

Decomposition:
- Shared package sdram_pkg holds the HADDR_WIDTH / bank / row / col width constants (shared with the controller) and the FSM state encodings S_IDLE, S_ISSUE, S_RDWAIT.
- One sub-module, sdram_req_fifo: synchronous FIFO, width 1+HADDR_WIDTH+8, parameter DEPTH, with level output and async active-low reset.

Test Plan:
- Reset with rst_n=0 mid-cycle and no clk edge → all outputs 0, req_ready=1, fifo_level=0 asynchronously.
- Write addr 0x0001234 data 0xA5, controller model acks 3 cycles later → ctl_wr_enable high for exactly 4 cycles with stable addr/data, low the cycle after ack, fifo_level back to 0, no rsp_valid.
- Read addr 0x1FFFFFF, ack after 1 cycle, ctl_rd_ready with data 0x3C 6 cycles later → rsp_valid=1, rsp_data=0x3C, rsp_err=0; held until rsp_ready.
- Push 5 requests back-to-back with ack withheld → req_ready=0 after 4 pushes, fifo_level=4. Release acks → requests issue in push order.
- Two reads queued, rsp_ready held low → second read not issued (ctl_rd_enable=0) until the first response is consumed.
- Read acked with no ctl_rd_ready → rsp_valid with rsp_err=1 and rsp_data=0x00 after RD_TIMEOUT cycles. A late ctl_rd_ready is then ignored.
